// File: rtl/scr_mem_arb.sv
// Screen RAM port arbiter: renderer fetches take priority, host writes drain from a small FIFO
// in free cycles, and host reads issue only once the FIFO is empty so they observe earlier writes.
module scr_mem_arb #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_active,
  input  logic [ADDR_W-1:0] i_disp_addr,
  input  logic              i_host_wr_valid,
  input  logic [ADDR_W-1:0] i_host_wr_addr,
  input  logic [DATA_W-1:0] i_host_wr_data,
  output logic              o_host_wr_ready,
  input  logic              i_host_rd_valid,
  input  logic [ADDR_W-1:0] i_host_rd_addr,
  output logic              o_host_rd_ready,
  output logic [DATA_W-1:0] o_host_rd_data,
  output logic              o_host_rd_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_PEND,
    ST_RD_CAP
  } rd_state_t;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_done;

  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_push;
  logic w_pop;
  logic w_rd_accept;
  logic w_rd_issue;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));

  assign o_host_wr_ready = !w_fifo_full && !i_rst;
  assign o_host_rd_ready = (r_state == ST_IDLE) && !i_rst;

  assign w_push      = i_host_wr_valid && o_host_wr_ready;
  assign w_rd_accept = i_host_rd_valid && o_host_rd_ready;
  // Pop uses the registered count, so a word pushed this cycle cannot leave until the next one.
  assign w_pop       = !i_rst && !i_disp_active && !w_fifo_empty;
  assign w_rd_issue  = (r_state == ST_RD_PEND) && !i_disp_active && w_fifo_empty;

  assign o_host_rd_data = r_rd_data;
  assign o_host_rd_done = r_rd_done;

  always_comb begin
    o_mem_addr  = i_disp_addr;
    o_mem_wdata = r_fifo_data[r_rd_ptr];
    o_mem_we    = 1'b0;
    if (w_pop) begin
      o_mem_addr = r_fifo_addr[r_rd_ptr];
      o_mem_we   = 1'b1;
    end else if (w_rd_issue) begin
      o_mem_addr = r_rd_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= i_host_wr_addr;
      r_fifo_data[r_wr_ptr] <= i_host_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture happens one cycle after issue; the port is free again during capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_rd_done <= 1'b0;
    end else begin
      r_rd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rd_accept) begin
            r_rd_addr <= i_host_rd_addr;
            r_state   <= ST_RD_PEND;
          end
        end
        ST_RD_PEND: begin
          if (w_rd_issue) begin
            r_state <= ST_RD_CAP;
          end
        end
        ST_RD_CAP: begin
          r_rd_data <= i_mem_rdata;
          r_rd_done <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr_mem_arb.sv
// Scoreboard bench for scr_mem_arb: a host-view memory image predicts read data and write order,
// while timed expectations check latency, readiness and reset behaviour.
module tb_scr_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispActive;
  logic [12:0] dispAddr;
  logic        wrValid;
  logic [12:0] wrAddr;
  logic [7:0]  wrData;
  logic        wrReady;
  logic        rdValid;
  logic [12:0] rdAddr;
  logic        rdReady;
  logic [7:0]  rdData;
  logic        rdDone;
  logic [12:0] memAddr;
  logic [7:0]  memWdata;
  logic        memWe;
  logic [7:0]  memRdata;

  typedef enum int {S_MEM_WE, S_MEM_ADDR, S_MEM_WDATA, S_WR_READY, S_RD_READY, S_RD_DONE, S_RD_DATA} sig_e;
  typedef struct {
    int unsigned cyc;
    sig_e        sig;
    logic [31:0] val;
  } dirItem_t;

  logic [7:0]  ram [8192];
  logic [7:0]  shadow [8192];
  logic [20:0] expWrQ [$];
  logic [7:0]  expRdQ [$];
  dirItem_t    dirQ [$];
  logic [12:0] pendRdAddr;
  int unsigned cycleNum = 0;
  int          checkCount = 0;
  int          errorCount = 0;
  logic        monitorOn = 1'b0;
  logic        finalReq = 1'b0;

  scr_mem_arb dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_disp_active(dispActive),
    .i_disp_addr(dispAddr),
    .i_host_wr_valid(wrValid),
    .i_host_wr_addr(wrAddr),
    .i_host_wr_data(wrData),
    .o_host_wr_ready(wrReady),
    .i_host_rd_valid(rdValid),
    .i_host_rd_addr(rdAddr),
    .o_host_rd_ready(rdReady),
    .o_host_rd_data(rdData),
    .o_host_rd_done(rdDone),
    .o_mem_addr(memAddr),
    .o_mem_wdata(memWdata),
    .o_mem_we(memWe),
    .i_mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  function automatic logic [7:0] defaultByte(input logic [12:0] a);
    return a[7:0] ^ {3'b101, a[12:8]};
  endfunction

  // Screen RAM model; it reloads a known image on reset so the host-view image can restart with it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8192; i++) ram[i] <= defaultByte(13'(i));
    end else if (memWe) begin
      ram[memAddr] <= memWdata;
    end
    memRdata <= ram[memAddr];
  end

  function automatic logic [31:0] sigValue(input sig_e s);
    case (s)
      S_MEM_WE:    return 32'(memWe);
      S_MEM_ADDR:  return 32'(memAddr);
      S_MEM_WDATA: return 32'(memWdata);
      S_WR_READY:  return 32'(wrReady);
      S_RD_READY:  return 32'(rdReady);
      S_RD_DONE:   return 32'(rdDone);
      S_RD_DATA:   return 32'(rdData);
      default:     return '0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cycleNum, actual, expected);
    end
  endtask

  task automatic resetShadow();
    for (int i = 0; i < 8192; i++) shadow[i] = defaultByte(13'(i));
  endtask

  task automatic expectAt(input int unsigned offset, input sig_e s, input logic [31:0] v);
    dirQ.push_back('{cycleNum + offset, s, v});
  endtask

  task automatic expectNow(input sig_e s, input logic [31:0] v);
    expectAt(0, s, v);
  endtask

  // Drives one cycle of inputs and records accepted transactions into the reference model.
  task automatic applyStimulus(input logic rstV, input logic dispV, input logic [12:0] dA,
                               input logic wrV, input logic [12:0] wA, input logic [7:0] wD,
                               input logic rdV, input logic [12:0] rA);
    @(posedge clk);
    #1;
    rst = rstV; dispActive = dispV; dispAddr = dA;
    wrValid = wrV; wrAddr = wA; wrData = wD;
    rdValid = rdV; rdAddr = rA;
    #1;
    if (rstV) begin
      resetShadow();
      expWrQ.delete();
      expRdQ.delete();
    end else begin
      if (wrV && wrReady) begin
        shadow[wA] = wD;
        expWrQ.push_back({wA, wD});
      end
      if (rdV && rdReady) begin
        expRdQ.push_back(shadow[rA]);
        pendRdAddr = rA;
      end
    end
  endtask

  task automatic idleCycle(input logic [12:0] dA);
    applyStimulus(1'b0, 1'b0, dA, 1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
  endtask

  // Monitor: compares every RAM write and read completion against the queues, plus timed expectations.
  initial begin
    logic [20:0] expW;
    logic [7:0]  expR;
    forever begin
      @(negedge clk);
      if (monitorOn) begin
        if (dispActive && !rst) begin
          checkOutput("muxWe", 32'(memWe), 32'd0);
          checkOutput("muxAddr", 32'(memAddr), 32'(dispAddr));
        end
        if (memWe) begin
          if (expWrQ.size() == 0) begin
            checkOutput("unexpectedWrite", 32'(memWe), 32'd0);
          end else begin
            expW = expWrQ.pop_front();
            checkOutput("memWrite", 32'({memAddr, memWdata}), 32'(expW));
          end
        end
        if (rdDone) begin
          if (expRdQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'(rdDone), 32'd0);
          end else begin
            expR = expRdQ.pop_front();
            checkOutput("readData", 32'(rdData), 32'(expR));
          end
        end
        for (int i = dirQ.size() - 1; i >= 0; i--) begin
          if (dirQ[i].cyc <= cycleNum) begin
            checkOutput(dirQ[i].sig.name(), sigValue(dirQ[i].sig), dirQ[i].val);
            dirQ.delete(i);
          end
        end
      end
      if (finalReq) begin
        checkOutput("drainWrQ", 32'(expWrQ.size()), 32'd0);
        checkOutput("drainRdQ", 32'(expRdQ.size()), 32'd0);
        checkOutput("drainDirQ", 32'(dirQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        dispRun;
    logic        wV;
    logic        rV;
    logic [12:0] wA;
    rst = 1'b1; dispActive = 1'b0; dispAddr = '0; wrValid = 1'b0; wrAddr = '0;
    wrData = '0; rdValid = 1'b0; rdAddr = '0; pendRdAddr = '0;
    resetShadow();

    // Reset with every request active
    applyStimulus(1'b1, 1'b1, 13'h1FFF, 1'b1, 13'h0AAA, 8'hFF, 1'b1, 13'h0BBB);
    @(negedge clk);
    #1 monitorOn = 1'b1;
    applyStimulus(1'b1, 1'b1, 13'h1FFF, 1'b1, 13'h0AAA, 8'hFF, 1'b1, 13'h0BBB);
    expectNow(S_MEM_WE, 0); expectNow(S_WR_READY, 0); expectNow(S_RD_READY, 0);
    expectNow(S_RD_DONE, 0); expectNow(S_RD_DATA, 0);
    idleCycle(13'h0);
    expectNow(S_WR_READY, 1); expectNow(S_RD_READY, 1);

    // Single write during blanking
    applyStimulus(1'b0, 1'b0, 13'h0010, 1'b1, 13'h0123, 8'h41, 1'b0, 13'h0);
    expectNow(S_MEM_WE, 0);
    idleCycle(13'h1555);
    expectNow(S_MEM_WE, 1); expectNow(S_MEM_ADDR, 32'h0123); expectNow(S_MEM_WDATA, 32'h41);
    idleCycle(13'h0AAA);
    expectNow(S_MEM_WE, 0); expectNow(S_MEM_ADDR, 32'h0AAA);

    // Fill the FIFO under active video, then drain in blanking
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 13'($urandom), 1'b1, 13'(13'h0200 + i), 8'(8'hC0 + i), 1'b0, 13'h0);
      expectNow(S_WR_READY, 1);
    end
    applyStimulus(1'b0, 1'b1, 13'($urandom), 1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
    expectNow(S_WR_READY, 0);
    for (int j = 0; j < 4; j++) begin
      idleCycle(13'($urandom));
      expectNow(S_MEM_WE, 1);
      expectNow(S_MEM_ADDR, 32'(13'h0200 + j));
      expectNow(S_MEM_WDATA, 32'(8'hC0 + j));
      expectNow(S_WR_READY, (j == 0) ? 32'd0 : 32'd1);
    end
    idleCycle(13'h0);
    expectNow(S_MEM_WE, 0);

    // Read right behind a write to the same address
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b1, 13'h0040, 8'h7E, 1'b0, 13'h0);
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 8'h0, 1'b1, 13'h0040);
    expectNow(S_MEM_WE, 1); expectNow(S_MEM_ADDR, 32'h0040); expectNow(S_RD_READY, 1);
    expectAt(1, S_MEM_WE, 0); expectAt(1, S_MEM_ADDR, 32'h0040); expectAt(1, S_RD_READY, 0);
    expectAt(2, S_RD_DONE, 0); expectAt(2, S_RD_READY, 0);
    expectAt(3, S_RD_DONE, 1); expectAt(3, S_RD_DATA, 32'h7E); expectAt(3, S_RD_READY, 1);
    expectAt(4, S_RD_DONE, 0);
    repeat (6) idleCycle(13'h0);

    // Read held off by the renderer for eleven cycles
    applyStimulus(1'b0, 1'b1, 13'($urandom), 1'b0, 13'h0, 8'h0, 1'b1, 13'h0100);
    expectAt(10, S_RD_READY, 0);
    expectAt(11, S_MEM_ADDR, 32'h0100); expectAt(11, S_MEM_WE, 0);
    expectAt(12, S_RD_DONE, 0);
    expectAt(13, S_RD_DONE, 1); expectAt(13, S_RD_DATA, 32'(shadow[13'h0100]));
    for (int k = 1; k <= 10; k++) applyStimulus(1'b0, 1'b1, 13'($urandom), 1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
    repeat (5) idleCycle(13'h1F00);

    // Reset landing on the capture cycle, with a write still buffered
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 8'h0, 1'b1, 13'h0055);
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b1, 13'h0077, 8'h99, 1'b0, 13'h0);
    applyStimulus(1'b1, 1'b1, 13'h0, 1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
    idleCycle(13'h0033);
    expectNow(S_RD_DONE, 0); expectNow(S_RD_DATA, 0); expectNow(S_RD_READY, 1);
    expectNow(S_WR_READY, 1); expectNow(S_MEM_WE, 0); expectNow(S_MEM_ADDR, 32'h0033);
    idleCycle(13'h0);
    expectNow(S_RD_DONE, 0); expectNow(S_MEM_WE, 0);

    // Random traffic; writes avoid the address of a read still in flight
    dispRun = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) dispRun = ~dispRun;
      wV = ($urandom_range(0, 99) < 40);
      rV = ($urandom_range(0, 99) < 30);
      wA = 13'($urandom_range(0, 31));
      if (expRdQ.size() != 0 && wA == pendRdAddr) wA = wA ^ 13'd1;
      applyStimulus(1'b0, dispRun, 13'($urandom), wV, wA, 8'($urandom), rV, 13'($urandom_range(0, 31)));
    end

    for (int d = 0; d < 200; d++) begin
      if (expWrQ.size() == 0 && expRdQ.size() == 0) break;
      idleCycle(13'h0);
    end
    repeat (3) idleCycle(13'h0);
    finalReq = 1'b1;
    repeat (5) @(posedge clk);
    $display("[TB] FAIL finish: monitor still running, expected summary");
    $fatal(1, "[TB] monitor did not finish");
  end

endmodule
